// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer_if
// Description : Fetch/control bundle between the PC sequencer and its core.
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_sequencer_if;
    logic       fetch_ready;
    logic       stall;
    logic       jump;
    logic       call;
    logic       ret;
    logic [7:0] jump_addr;
    logic       halt;
    logic [7:0] pc;
    logic       pc_valid;
    logic [7:0] link;
    logic [1:0] state;
    logic       trap;

    modport master (
        input  fetch_ready, stall, jump, call, ret, jump_addr, halt,
        output pc, pc_valid, link, state, trap
    );

    modport slave (
        output fetch_ready, stall, jump, call, ret, jump_addr, halt,
        input  pc, pc_valid, link, state, trap
    );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : 8-bit program counter sequencer with jump/call/ret, halt and
//               optional PC-overflow trap (macro PC_WRAP_TRAP_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter logic [7:0] RESET_VECTOR = 8'h00
) (
    input  wire logic      clk,
    input  wire logic      rst,
    pc_sequencer_if.master bus
);

    localparam logic [1:0] c_BOOT   = 2'd0;
    localparam logic [1:0] c_RUN    = 2'd1;
    localparam logic [1:0] c_HALTED = 2'd2;
    localparam logic [1:0] c_TRAP   = 2'd3;

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic [7:0] r_pc;
    logic [7:0] r_link;
    logic [7:0] w_pc_next;
    logic [7:0] w_link_next;
    logic       r_pc_valid;
    logic       w_handshake;
    logic       w_redirect;
    logic       w_incr;
    logic       w_wrap_trap;

    assign w_handshake = (r_state == c_RUN) && r_pc_valid && bus.fetch_ready;
    assign w_redirect  = bus.jump | bus.call | bus.ret;
    assign w_incr      = w_handshake && !bus.stall && !w_redirect && !bus.halt;

`ifdef PC_WRAP_TRAP_EN
    logic r_trap;

    assign w_wrap_trap = w_incr && (r_pc == 8'hFF);

    // Sticky until reset; the FSM parks in TRAP alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_trap <= 1'b0;
        end else if (w_wrap_trap) begin
            r_trap <= 1'b1;
        end
    end

    assign bus.trap = r_trap;
`else
    assign w_wrap_trap = 1'b0;
    assign bus.trap    = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_BOOT;
            r_pc_valid <= 1'b0;
            r_pc       <= RESET_VECTOR;
            r_link     <= 8'h00;
        end else begin
            r_state    <= w_state_next;
            r_pc_valid <= (w_state_next == c_RUN);
            r_pc       <= w_pc_next;
            r_link     <= w_link_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_BOOT: w_state_next = c_RUN;
            c_RUN: begin
                if (bus.halt) begin
                    w_state_next = c_HALTED;
                end else if (w_wrap_trap) begin
                    w_state_next = c_TRAP;
                end
            end
            default: w_state_next = r_state;
        endcase
    end

    // Datapath next values; halt outranks every redirect and the increment
    always_comb begin
        w_pc_next   = r_pc;
        w_link_next = r_link;
        if ((r_state == c_RUN) && !bus.halt) begin
            if (bus.jump) begin
                w_pc_next = bus.jump_addr;
            end else if (bus.call) begin
                w_link_next = r_pc + 8'd1;
                w_pc_next   = bus.jump_addr;
            end else if (bus.ret) begin
                w_pc_next = r_link;
            end else if (w_incr && !w_wrap_trap) begin
                w_pc_next = r_pc + 8'd1;
            end
        end
    end

    assign bus.pc       = r_pc;
    assign bus.pc_valid = r_pc_valid;
    assign bus.link     = r_link;
    assign bus.state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Vector table, reset-vector sequence and randomized model check.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

`ifdef PC_WRAP_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef struct {
        logic       rst;
        logic       fr;
        logic       stall;
        logic       jump;
        logic       call;
        logic       ret;
        logic       halt;
        logic [7:0] ja;
        logic [7:0] e_pc;
        logic [7:0] e_link;
        logic [1:0] e_state;
        logic       e_valid;
        logic       e_trap;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model state
    int m_pc, m_link, m_st, m_trap;

    pc_sequencer_if bus ();
    pc_sequencer_if bus2 ();

    pc_sequencer #(.RESET_VECTOR(8'h00)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    pc_sequencer #(.RESET_VECTOR(8'hC0)) u_dut_c0 (
        .clk (clk),
        .rst (rst2),
        .bus (bus2.master)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r, fr, st, j, c, rt, h, input logic [7:0] ja,
                                input logic [7:0] epc, elink, input logic [1:0] es,
                                input logic ev, et);
        vec_t v;
        v.rst = r; v.fr = fr; v.stall = st; v.jump = j; v.call = c; v.ret = rt;
        v.halt = h; v.ja = ja; v.e_pc = epc; v.e_link = elink; v.e_state = es;
        v.e_valid = ev; v.e_trap = et;
        return v;
    endfunction

    task automatic drive(input logic r, fr, st, j, c, rt, h, input logic [7:0] ja);
        rst = r;
        bus.fetch_ready = fr; bus.stall = st; bus.jump = j; bus.call = c;
        bus.ret = rt; bus.halt = h; bus.jump_addr = ja;
    endtask

    task automatic drive2(input logic r, fr, j, c, input logic [7:0] ja);
        rst2 = r;
        bus2.fetch_ready = fr; bus2.stall = 1'b0; bus2.jump = j; bus2.call = c;
        bus2.ret = 1'b0; bus2.halt = 1'b0; bus2.jump_addr = ja;
    endtask

    task automatic check2(input string tag, input logic [7:0] epc, elink,
                          input logic [1:0] es, input logic et);
        check({tag, ".pc"},    bus2.pc,    epc);
        check({tag, ".link"},  bus2.link,  elink);
        check({tag, ".state"}, {6'd0, bus2.state}, {6'd0, es});
        check({tag, ".trap"},  {7'd0, bus2.trap},  {7'd0, et});
    endtask

    // Spec-level reference: one clock edge's effect given the current inputs
    task automatic model_step();
        if (rst) begin
            m_pc = 0; m_link = 0; m_st = 0; m_trap = 0;
        end else if (m_st == 0) begin
            m_st = 1;
        end else if (m_st == 1) begin
            if (bus.halt) m_st = 2;
            else if (bus.jump) m_pc = int'(bus.jump_addr);
            else if (bus.call) begin
                m_link = (m_pc + 1) % 256;
                m_pc   = int'(bus.jump_addr);
            end
            else if (bus.ret) m_pc = m_link;
            else if (bus.fetch_ready && !bus.stall) begin
                if (TRAP_EN && m_pc == 255) begin
                    m_st = 3; m_trap = 1;
                end else begin
                    m_pc = (m_pc + 1) % 256;
                end
            end
        end
    endtask

    initial begin
        vec_t vecs[$];
        drive(1, 0, 0, 0, 0, 0, 0, 8'h00);
        drive2(1, 0, 0, 0, 8'h00);

        //           rst fr st j  c  rt h  ja      pc     link   st v  trap
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h01, 8'h00, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h02, 8'h00, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 8'h05, 8'h05, 8'h00, 1, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 8'h00, 8'h05, 8'h00, 1, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 8'h00, 8'h05, 8'h00, 1, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 8'h00, 8'h05, 8'h00, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h06, 8'h00, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h06, 8'h00, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 8'h10, 8'h10, 8'h00, 1, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 1, 1, 0, 8'h40, 8'h40, 8'h11, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h41, 8'h11, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 8'h00, 8'h11, 8'h11, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 8'h20, 8'h20, 8'h11, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0, 1, 8'h80, 8'h20, 8'h11, 2, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 1, 0, 0, 8'h33, 8'h20, 8'h11, 2, 0, 0));
        vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0, 8'h33, 8'h00, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 8'h77, 8'h00, 8'h00, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 8'h50, 8'h50, 8'h01, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 1, 1, 0, 0, 8'h60, 8'h60, 8'h01, 1, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 1, 0, 8'h00, 8'h01, 8'h01, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 8'hFE, 8'hFE, 8'h01, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 8'h00, 8'hFF, 8'h01, 1, 1, 0));
        vecs.push_back(TRAP_EN ? mk(0, 1, 0, 0, 0, 0, 0, 8'h00, 8'hFF, 8'h01, 3, 0, 1)
                               : mk(0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h01, 1, 1, 0));
        vecs.push_back(TRAP_EN ? mk(0, 1, 0, 1, 0, 0, 0, 8'h12, 8'hFF, 8'h01, 3, 0, 1)
                               : mk(0, 1, 0, 1, 0, 0, 0, 8'h12, 8'h12, 8'h01, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0));

        foreach (vecs[i]) begin
            vec_t v;
            string tag;
            v = vecs[i];
            tag = $sformatf("vec%0d", i);
            drive(v.rst, v.fr, v.stall, v.jump, v.call, v.ret, v.halt, v.ja);
            cyc();
            check({tag, ".pc"},    bus.pc,   v.e_pc);
            check({tag, ".link"},  bus.link, v.e_link);
            check({tag, ".state"}, {6'd0, bus.state},    {6'd0, v.e_state});
            check({tag, ".valid"}, {7'd0, bus.pc_valid}, {7'd0, v.e_valid});
            check({tag, ".trap"},  {7'd0, bus.trap},     {7'd0, v.e_trap});
        end

        // Non-zero reset vector: reset mid-call and from the wrap/trap point
        drive2(1, 0, 0, 0, 8'h00); cyc(); check2("rv.rst", 8'hC0, 8'h00, 0, 0);
        drive2(0, 1, 0, 0, 8'h00); cyc(); check2("rv.boot", 8'hC0, 8'h00, 1, 0);
        cyc();                            check2("rv.inc", 8'hC1, 8'h00, 1, 0);
        drive2(1, 1, 0, 1, 8'h70); cyc(); check2("rv.midcall", 8'hC0, 8'h00, 0, 0);
        drive2(0, 0, 0, 0, 8'h00); cyc(); check2("rv.run", 8'hC0, 8'h00, 1, 0);
        drive2(0, 0, 0, 1, 8'h70); cyc(); check2("rv.call", 8'h70, 8'hC1, 1, 0);
        drive2(0, 0, 1, 0, 8'hFF); cyc(); check2("rv.jff", 8'hFF, 8'hC1, 1, 0);
        drive2(0, 1, 0, 0, 8'h00); cyc();
        check2("rv.top", TRAP_EN ? 8'hFF : 8'h00, 8'hC1, TRAP_EN ? 2'd3 : 2'd1, TRAP_EN);
        drive2(1, 1, 0, 0, 8'h00); cyc(); check2("rv.rst2", 8'hC0, 8'h00, 0, 0);

        // Randomized traffic against the reference model
        m_pc = 0; m_link = 0; m_st = 0; m_trap = 0;
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] ja;
            ja = ($urandom_range(0, 3) == 0) ? 8'(8'hFC + $urandom_range(0, 3)) : 8'($urandom);
            drive((i == 0) || ($urandom_range(0, 79) == 0),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 99) == 0, ja);
            model_step();
            cyc();
            check("rnd.pc",    bus.pc,   8'(m_pc));
            check("rnd.link",  bus.link, 8'(m_link));
            check("rnd.state", {6'd0, bus.state},    8'(m_st));
            check("rnd.valid", {7'd0, bus.pc_valid}, (m_st == 1) ? 8'd1 : 8'd0);
            check("rnd.trap",  {7'd0, bus.trap},     8'(m_trap));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
